add_seq_ctrl: RTL and testbench

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

---
 rtl/add_seq_ctrl_if.sv | 37 +++
 rtl/add_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_add_seq_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// add_seq_ctrl_if
// Request/response bundle for the nibble-serial adder controller.
//   Request side : in_valid, in_ready, a, b, cin, sub
//   Response side: out_valid, out_ready, sum, cout
//   Status       : busy
// Modports:
//   master - the requester/consumer (drives operands and out_ready)
//   slave  - the add_seq_ctrl block (drives in_ready, result and status)
// ----------------------------------------------------------------------------
interface add_seq_ctrl_if #(
    parameter int NIB = 4
);
    localparam int W = 4 * NIB;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// ----------------------------------------------------------------------------
// add_seq_ctrl
// Sequential W-bit adder/subtractor (W = 4*NIB) built around a single 4-bit
// ripple adder. One nibble is processed per clock, LSB nibble first; the
// inter-nibble carry lives only in carry_r.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - add_seq_ctrl_if.slave: in_valid/in_ready/a/b/cin/sub request,
//          out_valid/out_ready/sum/cout response, busy status
// Subtract is A + ~B + 1, so cout=1 means "no borrow"; cin is ignored then.
// ----------------------------------------------------------------------------

// 4-bit ripple-carry adder (team building block).
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] carry_s;

    // Bit-serial ripple through four full adders.
    always_comb begin
        carry_s    = 5'b00000;
        sum        = 4'b0000;
        carry_s[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        cout = carry_s[4];
    end
endmodule

module add_seq_ctrl #(
    parameter int NIB = 4
) (
    input  logic           clk,
    input  logic           rst,
    add_seq_ctrl_if.slave  bus
);
    localparam int W     = 4 * NIB;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             sub_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;
    logic [W-1:0]     sum_r;
    logic             cout_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             idle_r;

    logic [IDX_W+1:0] nib_base_s;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [3:0]       add_sum_s;
    logic             add_cout_s;

    // Select the current operand nibbles; B is inverted for subtract.
    always_comb begin
        nib_base_s = {idx_r, 2'b00};
        a_nib_s    = a_r[nib_base_s +: 4];
        if (sub_r) begin
            b_nib_s = ~b_r[nib_base_s +: 4];
        end else begin
            b_nib_s = b_r[nib_base_s +: 4];
        end
    end

    adder_4bit u_adder (
        .a    (a_nib_s),
        .b    (b_nib_s),
        .cin  (carry_r),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            sub_r       <= 1'b0;
            carry_r     <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            sum_r       <= {W{1'b0}};
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            idle_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // in_ready is idle_r gated by rst, so in_valid alone is the handshake here.
                    if (bus.in_valid) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        sub_r   <= bus.sub;
                        carry_r <= bus.sub ? 1'b1 : bus.cin;
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        idle_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sum_r[nib_base_s +: 4] <= add_sum_s;
                    carry_r                <= add_cout_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r       <= {IDX_W{1'b0}};
                        cout_r      <= add_cout_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // Return to IDLE only; a new request is taken on a later edge.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        idle_r      <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    idle_r      <= 1'b1;
                    idx_r       <= {IDX_W{1'b0}};
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready must already be low during the reset cycle itself.
    assign bus.in_ready  = idle_r & ~rst;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_add_seq_ctrl
// Self-checking bench for add_seq_ctrl: directed corner cases followed by
// randomized operations, compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_add_seq_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    add_seq_ctrl_if #(.NIB(NIB)) bus ();

    add_seq_ctrl #(.NIB(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] nxt_a;
    logic [W-1:0] nxt_b;
    logic         nxt_cin;
    logic         nxt_sub;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic, {cout, sum}.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        if (sub) begin
            ref_op = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        end else begin
            ref_op = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random(input logic valid);
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.cin      = 1'($urandom_range(0, 1));
        bus.sub      = 1'($urandom_range(0, 1));
        bus.in_valid = valid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
        step();
        step();
        check_val("rst_sum", 64'(bus.sum), 64'd0);
        check_val("rst_cout", 64'(bus.cout), 64'd0);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        #1;
        check_val("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
    endtask

    // Called #1 after the accepting edge; follows the op to its handshake.
    task automatic finish_op(input logic [W:0] exp, input bit scramble, input int hold, input bit keep);
        int cnt = 0;
        check_val("busy_on_accept", 64'(bus.busy), 64'd1);
        check_val("in_ready_run", 64'(bus.in_ready), 64'd0);
        while (bus.out_valid !== 1'b1 && cnt < 3 * NIB) begin
            if (scramble) begin
                drive_random(1'($urandom_range(0, 1)));
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            cnt++;
            check_val("busy_run", 64'(bus.busy), 64'd1);
        end
        check_val("latency", 64'(cnt), 64'(NIB));
        check_val("result", 64'({bus.cout, bus.sum}), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            drive_random(1'b1);
            step();
            check_val("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check_val("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check_val("hold_result", 64'({bus.cout, bus.sum}), 64'(exp));
        end
        nxt_a   = bus.a;
        nxt_b   = bus.b;
        nxt_cin = bus.cin;
        nxt_sub = bus.sub;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        if (!keep) begin
            bus.in_valid = 1'b0;
        end
        check_val("hs_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("hs_busy", 64'(bus.busy), 64'd0);
        check_val("hs_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            bus.in_valid = 1'b0;
            step();
            w++;
        end
        check_val("ready_wait", 64'(bus.in_ready), 64'd1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        step();
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input bit scramble, input int hold, input bit keep);
        issue(a, b, cin, sub);
        finish_op(ref_op(a, b, cin, sub), scramble, hold, keep);
    endtask

    // Watch for any result presented after an aborting reset.
    task automatic watch_no_valid(input string tag);
        int seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.out_valid === 1'b1) begin
                seen++;
            end
        end
        check_val(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = {W{1'b0}};
        bus.b         = {W{1'b0}};
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        nxt_a         = {W{1'b0}};
        nxt_b         = {W{1'b0}};
        nxt_cin       = 1'b0;
        nxt_sub       = 1'b0;

        do_reset();

        // Directed corner cases.
        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h1234, 16'h0234, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 0, 1'b0);

        // Backpressure in DONE, then the pending request is taken one cycle after release.
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        step();
        finish_op(ref_op(nxt_a, nxt_b, nxt_cin, nxt_sub), 1'b0, 0, 1'b0);

        // Reset in the second RUN cycle aborts the operation.
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_val("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("abort_sum", 64'(bus.sum), 64'd0);
        check_val("abort_busy", 64'(bus.busy), 64'd0);
        watch_no_valid("abort_run_no_result");
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Reset while the result is waiting in DONE.
        issue(16'hABCD, 16'h1111, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            step();
        end
        check_val("done_before_rst", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_val("abort_done_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("abort_done_cout", 64'(bus.cout), 64'd0);
        watch_no_valid("abort_done_no_result");

        // Randomized operations with inputs churning during RUN.
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule
